mc_decoder: RTL and testbench
=============================

MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 Parameter EXT_DP, default 1: 1 enables the extended data-processing set (EOR, MOV, CMP, TST); 0 restricts decode to ADD/SUB/AND/ORR.
REQ-002 Parameter WAIT_EN, default 1: 1 lets mem_ready stall memory states; 0 ignores mem_ready.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 Op  input  2  instruction class: 00 DP, 01 LDR/STR, 10 B, 11 illegal.
REQ-006 Funct  input  6  instruction bits [25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) or L (memory).
REQ-007 Rd  input  4  destination register.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA  output  1 each  datapath strobes and selects.
REQ-010 ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW  output  2 each  datapath selects and flag-write enables.
REQ-011 ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV (pass B).
REQ-012 PCS  output  1  PC-source request.
REQ-013 NoWrite  output  1  current DP command discards its result.
REQ-014 retire  output  1  one-cycle pulse on the final cycle of every instruction.
REQ-015 illegal  output  1  sticky flag: an Op=11 instruction was decoded.

Function
REQ-016 Main FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; go to DECODE.
REQ-018 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; go to MEMADR if Op=01, EXECI if Op=00 and Funct[5]=1, EXECR if Op=00 and Funct[5]=0, BRANCH if Op=10, otherwise FETCH with illegal set and retire=1.
REQ-019 MEMADR: ALUSrcA=0, ALUSrcB=01; go to MEMRD if Funct[0]=1, otherwise MEMWR.
REQ-020 MEMRD: AdrSrc=1, ResultSrc=00; go to MEMWB.
REQ-021 MEMWB: ResultSrc=01, RegW=1, retire=1; go to FETCH.
REQ-022 MEMWR: AdrSrc=1, ResultSrc=00, MemW=1; go to FETCH with retire=1.
REQ-023 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1; go to ALUWB.
REQ-024 EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1; go to ALUWB.
REQ-025 ALUWB: ResultSrc=00, RegW=~NoWrite, retire=1; go to FETCH.
REQ-026 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, retire=1; go to FETCH.
REQ-027 Wait handling, WAIT_EN=1 only: FETCH, MEMRD and MEMWR hold state and outputs while mem_ready=0; IRWrite, NextPC and MemW are asserted only in the cycle mem_ready=1; retire from MEMWR fires only in that cycle.
REQ-028 Any output not listed for a state is 0; ImmSrc=Op and RegSrc={Op==01 & ~Funct[0], Op==10} in every state.
REQ-029 ALU decode, ALUOp=1, by cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (SUB), 1000 TST (AND); NoWrite=1 for CMP and TST only.
REQ-030 With EXT_DP=0, or for any unlisted cmd, ALUControl=ADD and NoWrite=0.
REQ-031 FlagW[1]=S and FlagW[0]=S AND (ADD, SUB or CMP) when ALUOp=1; CMP and TST force FlagW[1]=1 regardless of S.
REQ-032 When ALUOp=0, ALUControl=000, FlagW=00 and NoWrite=0.
REQ-033 PCS = (Rd==1111 AND RegW) OR Branch, evaluated in the same cycle.

Reset
REQ-034 With rst_n=0 at a clock edge, the next state is FETCH and illegal clears, overriding any transition, including mid-instruction and mid-wait.
REQ-035 During and directly after reset, all strobes (IRWrite, NextPC, RegW, MemW, Branch, retire) are 0 until FETCH is entered.

Verification
REQ-036 ADD register form (Op=00, Funct=001000), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; ALUControl=000, RegW=1 in ALUWB, retire pulse on cycle 4.
REQ-037 LDR (Op=01, Funct[0]=1) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB with RegW=1; total 7 cycles.
REQ-038 CMP (cmd=1010, S=1), EXT_DP=1 -> ALUControl=001, FlagW=11, NoWrite=1, RegW=0 in ALUWB.
REQ-039 Same CMP with EXT_DP=0 -> ALUControl=000, NoWrite=0, RegW=1.
REQ-040 Op=11 -> DECODE returns to FETCH with illegal=1 and retire=1; rst_n=0 -> illegal=0.
REQ-041 Branch and MOV to Rd=1111 -> PCS=1 in BRANCH and ALUWB respectively; rst_n pulled low in MEMADR -> FETCH next cycle with MemW never asserted.

Source files
------------

// File: rtl/mc_decoder.sv
// -----------------------------------------------------------------------------
// mc_decoder -- control unit for a multicycle ARM-style datapath.
//
// The main FSM walks every instruction through FETCH/DECODE and then a
// class-specific path (memory, data-processing or branch). The per-state
// controls are registered alongside the state. The only same-cycle gating
// applied to them is:
//   - memory-completion gating from mem_ready (when WAIT_EN=1),
//   - reset gating of the strobes,
//   - the ALU decode taken from Funct.
//
// Handshake: mem_ready is a completion qualifier, not a request/grant pair.
// While FETCH, MEMRD or MEMWR is active, the access is outstanding. The state
// and all its selects are held every cycle mem_ready=0. The cycle that sees
// mem_ready=1 is the one where the access completes: only in that cycle do the
// commit strobes fire (IRWrite/NextPC in FETCH, MemW and retire in MEMWR).
// With WAIT_EN=0 every access completes in its first cycle.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   Op[1:0]           instruction class (00 DP, 01 LDR/STR, 10 B, 11 illegal)
//   Funct[5:0]        {I, cmd[3:0], S/L}
//   Rd[3:0]           destination register (R15 write => PC source)
//   mem_ready         memory finishes the current access this cycle
//   IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA   strobes / selects
//   ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW              2-bit selects
//   ALUControl[2:0]   000 ADD 001 SUB 010 AND 011 ORR 100 EOR 101 MOV
//   PCS               PC-source request
//   NoWrite           current DP command discards its result (CMP/TST)
//   retire            one-cycle pulse on the last cycle of each instruction
//   illegal           sticky: an Op=11 instruction was decoded
//   dbg_state_o[3:0]  current FSM state (encoding listed at state_t)
// -----------------------------------------------------------------------------
module mc_decoder #(
  parameter bit EXT_DP  = 1'b1,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic [2:0] ALUControl,
  output logic       PCS,
  output logic       NoWrite,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] dbg_state_o
);

  // Fixed encoding so the debug port can be decoded without this source.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  // Registered per-state controls; one-hot state markers feed the gated strobes.
  typedef struct packed {
    logic       fetch;
    logic       decode;
    logic       memwb;
    logic       memwr;
    logic       aluwb;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctl_t;

  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.decode     = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR: c.alu_src_b = 2'b01;
      S_MEMRD:  c.adr_src   = 1'b1;
      S_MEMWB: begin
        c.memwb      = 1'b1;
        c.result_src = 2'b01;
      end
      S_MEMWR: begin
        c.memwr   = 1'b1;
        c.adr_src = 1'b1;
      end
      S_EXECR:  c.alu_op = 1'b1;
      S_EXECI: begin
        c.alu_op    = 1'b1;
        c.alu_src_b = 2'b01;
      end
      // The decoded command stays in force through write-back so RegW can
      // honour NoWrite and FlagW is valid while the result is committed.
      S_ALUWB: begin
        c.aluwb  = 1'b1;
        c.alu_op = 1'b1;
      end
      S_BRANCH: begin
        c.branch     = 1'b1;
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctl_t   ctl_q;
  logic   illegal_q;

  logic mem_wait;  // an outstanding access must be held this cycle
  logic mem_done;  // the outstanding access completes this cycle
  assign mem_wait = WAIT_EN & ~mem_ready;
  assign mem_done = ~mem_wait;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_done) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctl_q     <= ctl_for(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_for(state_d);
      if (ctl_q.decode && (Op == 2'b11)) illegal_q <= 1'b1;
    end
  end

  // ALU decode. Extended commands fall back to ADD when EXT_DP=0.
  logic [3:0] cmd;
  logic       s_bit;
  logic [2:0] alu_ctrl;
  logic       no_write;
  logic [1:0] flag_w;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  always_comb begin
    alu_ctrl = ALU_ADD;
    no_write = 1'b0;
    flag_w   = 2'b00;
    if (ctl_q.alu_op) begin
      case (cmd)
        4'b0100: alu_ctrl = ALU_ADD;
        4'b0010: alu_ctrl = ALU_SUB;
        4'b0000: alu_ctrl = ALU_AND;
        4'b1100: alu_ctrl = ALU_ORR;
        4'b0001: if (EXT_DP) alu_ctrl = ALU_EOR;
        4'b1101: if (EXT_DP) alu_ctrl = ALU_MOV;
        4'b1010: if (EXT_DP) begin  // CMP
          alu_ctrl = ALU_SUB;
          no_write = 1'b1;
        end
        4'b1000: if (EXT_DP) begin  // TST
          alu_ctrl = ALU_AND;
          no_write = 1'b1;
        end
        default: ;
      endcase
      // Only CMP and TST raise no_write, and both always update NZ.
      flag_w[1] = s_bit | no_write;
      // C/V only make sense for arithmetic; CMP decodes to SUB here.
      flag_w[0] = s_bit & ((alu_ctrl == ALU_ADD) | (alu_ctrl == ALU_SUB));
    end
  end

  // Strobes are forced low while reset is asserted so nothing commits
  // from a stale mid-instruction state.
  logic strobe_en;
  assign strobe_en = rst_n;

  assign IRWrite    = strobe_en & ctl_q.fetch & mem_done;
  assign NextPC     = strobe_en & ctl_q.fetch & mem_done;
  assign MemW       = strobe_en & ctl_q.memwr & mem_done;
  assign RegW       = strobe_en & (ctl_q.memwb | (ctl_q.aluwb & ~no_write));
  assign Branch     = strobe_en & ctl_q.branch;
  assign retire     = strobe_en & ((ctl_q.decode & (Op == 2'b11)) | ctl_q.memwb |
                                   (ctl_q.memwr & mem_done) | ctl_q.aluwb |
                                   ctl_q.branch);
  assign AdrSrc     = ctl_q.adr_src;
  assign ALUSrcA    = ctl_q.alu_src_a;
  assign ALUSrcB    = ctl_q.alu_src_b;
  assign ResultSrc  = ctl_q.result_src;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], Op == 2'b10};
  assign FlagW      = flag_w;
  assign ALUControl = alu_ctrl;
  assign NoWrite    = no_write;
  assign PCS        = ((Rd == 4'hF) & RegW) | Branch;
  assign illegal    = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_decoder.sv
// -----------------------------------------------------------------------------
// tb_mc_decoder -- self-checking bench for mc_decoder.
// Instance 0: EXT_DP=1, WAIT_EN=1. Instance 1: EXT_DP=0, WAIT_EN=0.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mc_decoder;

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
    logic       adrsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] ressrc;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] flagw;
    logic [2:0] aluc;
    logic       pcs;
    logic       nowr;
    logic       ret;
    logic       ill;
  } vec_t;

  localparam logic [23:0] ALL = 24'hFFFFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  op_s    [2];
  logic [5:0]  funct_s [2];
  logic [3:0]  rd_s    [2];
  logic        mr_s    [2];
  logic        rstn_s  [2];
  logic [23:0] obs     [2];
  logic [3:0]  dbg     [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic irw, npc, regw, memw, br, adr, srca, pcs, nowr, ret, ill;
    logic [1:0] srcb, res, imm, regsrc, flagw;
    logic [2:0] aluc;
    mc_decoder #(.EXT_DP(gi == 0), .WAIT_EN(gi == 0)) u_dut (
      .clk(clk), .rst_n(rstn_s[gi]), .Op(op_s[gi]), .Funct(funct_s[gi]),
      .Rd(rd_s[gi]), .mem_ready(mr_s[gi]),
      .IRWrite(irw), .NextPC(npc), .RegW(regw), .MemW(memw), .Branch(br),
      .AdrSrc(adr), .ALUSrcA(srca), .ALUSrcB(srcb), .ResultSrc(res),
      .ImmSrc(imm), .RegSrc(regsrc), .FlagW(flagw), .ALUControl(aluc),
      .PCS(pcs), .NoWrite(nowr), .retire(ret), .illegal(ill),
      .dbg_state_o(dbg[gi])
    );
    assign obs[gi] = {irw, npc, regw, memw, br, adr, srca, srcb, res, imm,
                      regsrc, flagw, aluc, pcs, nowr, ret, ill};
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  logic        ill_m;
  logic [23:0] exp_q [$];
  logic        mr_q  [$];
  logic [1:0]  st_op;
  logic [5:0]  st_f;
  logic [3:0]  st_rd;

  task automatic check_vec(input string name, input logic [23:0] act,
                           input logic [23:0] exp, input logic [23:0] mask);
    n_vec++;
    if (((act ^ exp) & mask) != 24'h0) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (mask %h) t=%0t",
               name, act & mask, exp & mask, mask, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] strobe_mask();
    vec_t m;
    m = '0;
    m.irw = 1'b1; m.npc = 1'b1; m.regw = 1'b1; m.memw = 1'b1;
    m.br = 1'b1; m.ret = 1'b1; m.pcs = 1'b1;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int sel, input logic mr, input logic rst);
    @(negedge clk);
    op_s[sel]    = st_op;
    funct_s[sel] = st_f;
    rd_s[sel]    = st_rd;
    mr_s[sel]    = mr;
    rstn_s[sel]  = rst;
    #1;
  endtask

  task automatic do_reset(input int sel);
    for (int i = 0; i < 2; i++) begin
      step(sel, 1'b1, 1'b0);
      check_vec("rst_strobes", obs[sel], 24'h0, strobe_mask());
    end
    ill_m = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic vec_t base_v(input logic [1:0] op, input logic [5:0] f);
    vec_t v;
    v = '0;
    v.immsrc = op;
    v.regsrc = {op == 2'b01 && !f[0], op == 2'b10};
    v.ill    = ill_m;
    return v;
  endfunction

  // Architectural meaning of a DP command.
  function automatic void alu_sem(input logic [3:0] cmd, input logic s, input logic ext,
                                  output logic [2:0] aluc, output logic [1:0] fw,
                                  output logic nw);
    logic cmp, tst;
    cmp = ext && cmd == 4'd10;
    tst = ext && cmd == 4'd8;
    case (cmd)
      4'd4:    aluc = 3'd0;
      4'd2:    aluc = 3'd1;
      4'd0:    aluc = 3'd2;
      4'd12:   aluc = 3'd3;
      4'd1:    aluc = ext ? 3'd4 : 3'd0;
      4'd13:   aluc = ext ? 3'd5 : 3'd0;
      4'd10:   aluc = ext ? 3'd1 : 3'd0;
      4'd8:    aluc = ext ? 3'd2 : 3'd0;
      default: aluc = 3'd0;
    endcase
    nw    = cmp | tst;
    fw[1] = s | cmp | tst;
    fw[0] = s & (aluc == 3'd0 || aluc == 3'd1);
  endfunction

  function automatic void push(input vec_t v, input logic [3:0] rd, input logic mr);
    v.pcs = (rd == 4'hF && v.regw) || v.br;
    exp_q.push_back(v);
    mr_q.push_back(mr);
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction, plus the mem_ready
  // stream that produces the requested stalls.
  function automatic void build_trace(input int sel, input logic [1:0] op,
                                      input logic [5:0] f, input logic [3:0] rd,
                                      input int fstall, input int mstall);
    vec_t v;
    logic [2:0] ac;
    logic [1:0] fw;
    logic nw, wt, ext;
    wt  = (sel == 0);
    ext = (sel == 0);
    v = base_v(op, f); v.srca = 1'b1; v.srcb = 2'd2; v.ressrc = 2'd2;
    if (wt) for (int i = 0; i < fstall; i++) push(v, rd, 1'b0);
    v.irw = 1'b1; v.npc = 1'b1;
    push(v, rd, wt ? 1'b1 : rnd1());
    v = base_v(op, f); v.srca = 1'b1; v.srcb = 2'd2; v.ressrc = 2'd2;
    v.ret = (op == 2'd3);
    push(v, rd, rnd1());
    case (op)
      2'd0: begin
        alu_sem(f[4:1], f[0], ext, ac, fw, nw);
        v = base_v(op, f); v.srcb = f[5] ? 2'd1 : 2'd0;
        v.aluc = ac; v.flagw = fw; v.nowr = nw;
        push(v, rd, rnd1());
        v = base_v(op, f); v.aluc = ac; v.flagw = fw; v.nowr = nw;
        v.regw = !nw; v.ret = 1'b1;
        push(v, rd, rnd1());
      end
      2'd1: begin
        v = base_v(op, f); v.srcb = 2'd1;
        push(v, rd, rnd1());
        v = base_v(op, f); v.adrsrc = 1'b1;
        if (wt) for (int i = 0; i < mstall; i++) push(v, rd, 1'b0);
        if (f[0]) begin
          push(v, rd, wt ? 1'b1 : rnd1());
          v = base_v(op, f); v.ressrc = 2'd1; v.regw = 1'b1; v.ret = 1'b1;
          push(v, rd, rnd1());
        end else begin
          v.memw = 1'b1; v.ret = 1'b1;
          push(v, rd, wt ? 1'b1 : rnd1());
        end
      end
      2'd2: begin
        v = base_v(op, f); v.srcb = 2'd1; v.ressrc = 2'd2; v.br = 1'b1; v.ret = 1'b1;
        push(v, rd, rnd1());
      end
      default: ill_m = 1'b1;
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int         sel;
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    int         st_at;
    int         st_n;
    int         cyc;
    logic [2:0] aluc;
    logic [1:0] fw;
    logic       nw;
    logic       regw;
    logic       memw;
    logic       pcs;
    logic       ill_after;
  } tv_t;

  tv_t tbl [20];

  task automatic run_entry(input tv_t t);
    vec_t o, e, m;
    bit found;
    do_reset(t.sel);
    st_op = t.op; st_f = t.f; st_rd = t.rd;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      step(t.sel, (c >= t.st_at && c < t.st_at + t.st_n) ? 1'b0 : 1'b1, 1'b1);
      o = vec_t'(obs[t.sel]);
      if (o.ret) begin
        check_int("instr_cycles", c + 1, t.cyc);
        e = '0; m = '0;
        e.aluc = t.aluc; e.flagw = t.fw; e.nowr = t.nw; e.regw = t.regw;
        e.memw = t.memw; e.pcs = t.pcs;
        m.aluc = '1; m.flagw = '1; m.nowr = 1'b1; m.regw = 1'b1;
        m.memw = 1'b1; m.pcs = 1'b1;
        check_vec("retire_fields", obs[t.sel], e, m);
        found = 1;
        break;
      end
    end
    if (!found) check_int("retire_timeout", 0, 1);
    step(t.sel, 1'b1, 1'b1);
    o = vec_t'(obs[t.sel]);
    check_int("illegal_after", int'(o.ill), int'(t.ill_after));
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t e, m;
    logic [1:0] rop;
    for (int i = 0; i < 2; i++) begin
      op_s[i] = 2'd0; funct_s[i] = 6'd0; rd_s[i] = 4'd0;
      mr_s[i] = 1'b1; rstn_s[i] = 1'b0;
    end
    st_op = 2'd0; st_f = 6'd0; st_rd = 4'd0; ill_m = 1'b0;

    //            sel op     funct      rd  st_at st_n cyc aluc fw  nw regw memw pcs ill
    tbl[0]  = '{0, 2'd0, 6'b001000, 4'd2,  99, 0, 4, 3'd0, 2'b00, 0, 1, 0, 0, 0};  // ADD reg
    tbl[1]  = '{0, 2'd0, 6'b010101, 4'd0,  99, 0, 4, 3'd1, 2'b11, 1, 0, 0, 0, 0};  // CMP
    tbl[2]  = '{1, 2'd0, 6'b010101, 4'd0,  99, 0, 4, 3'd0, 2'b11, 0, 1, 0, 0, 0};  // CMP, no ext
    tbl[3]  = '{0, 2'd0, 6'b111010, 4'd15, 99, 0, 4, 3'd5, 2'b00, 0, 1, 0, 1, 0};  // MOV pc
    tbl[4]  = '{0, 2'd2, 6'b000000, 4'd0,  99, 0, 3, 3'd0, 2'b00, 0, 0, 0, 1, 0};  // B
    tbl[5]  = '{0, 2'd1, 6'b011001, 4'd3,  99, 0, 5, 3'd0, 2'b00, 0, 1, 0, 0, 0};  // LDR
    tbl[6]  = '{0, 2'd1, 6'b011000, 4'd3,  99, 0, 4, 3'd0, 2'b00, 0, 0, 1, 0, 0};  // STR
    tbl[7]  = '{0, 2'd0, 6'b010000, 4'd1,  99, 0, 4, 3'd2, 2'b10, 1, 0, 0, 0, 0};  // TST S=0
    tbl[8]  = '{0, 2'd0, 6'b100101, 4'd4,  99, 0, 4, 3'd1, 2'b11, 0, 1, 0, 0, 0};  // SUBS imm
    tbl[9]  = '{0, 2'd0, 6'b111001, 4'd5,  99, 0, 4, 3'd3, 2'b10, 0, 1, 0, 0, 0};  // ORRS imm
    tbl[10] = '{1, 2'd0, 6'b000011, 4'd6,  99, 0, 4, 3'd0, 2'b11, 0, 1, 0, 0, 0};  // EORS, no ext
    tbl[11] = '{0, 2'd0, 6'b000011, 4'd6,  99, 0, 4, 3'd4, 2'b10, 0, 1, 0, 0, 0};  // EORS
    tbl[12] = '{0, 2'd0, 6'b001110, 4'd7,  99, 0, 4, 3'd0, 2'b00, 0, 1, 0, 0, 0};  // cmd 0111
    tbl[13] = '{0, 2'd0, 6'b001001, 4'd15, 99, 0, 4, 3'd0, 2'b11, 0, 1, 0, 1, 0};  // ADDS pc
    tbl[14] = '{0, 2'd3, 6'b000000, 4'd0,  99, 0, 2, 3'd0, 2'b00, 0, 0, 0, 0, 1};  // illegal
    tbl[15] = '{0, 2'd1, 6'b011001, 4'd3,   3, 2, 7, 3'd0, 2'b00, 0, 1, 0, 0, 0};  // LDR wait 2
    tbl[16] = '{0, 2'd0, 6'b001000, 4'd2,   0, 3, 7, 3'd0, 2'b00, 0, 1, 0, 0, 0};  // fetch wait 3
    tbl[17] = '{1, 2'd1, 6'b011001, 4'd3,   3, 2, 5, 3'd0, 2'b00, 0, 1, 0, 0, 0};  // wait ignored
    tbl[18] = '{0, 2'd1, 6'b011000, 4'd3,   3, 1, 5, 3'd0, 2'b00, 0, 0, 1, 0, 0};  // STR wait 1
    tbl[19] = '{0, 2'd0, 6'b010101, 4'd15, 99, 0, 4, 3'd1, 2'b11, 1, 0, 0, 0, 0};  // CMP rd=pc

    for (int i = 0; i < 20; i++) run_entry(tbl[i]);

    // Reset asserted in MEMADR of a store: FETCH next, MemW never seen.
    do_reset(0);
    st_op = 2'd1; st_f = 6'b011000; st_rd = 4'd2;
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0);
    check_vec("rst_in_memadr", obs[0], 24'h0, strobe_mask());
    step(0, 1'b1, 1'b1);
    ill_m = 1'b0;
    e = base_v(2'd1, 6'b011000); e.srca = 1'b1; e.srcb = 2'd2; e.ressrc = 2'd2;
    e.irw = 1'b1; e.npc = 1'b1;
    check_vec("fetch_after_rst", obs[0], e, ALL);
    check_int("dbg_fetch", int'(dbg[0]), 0);
    step(0, 1'b1, 1'b1);
    e.irw = 1'b0; e.npc = 1'b0;
    check_vec("decode_after_rst", obs[0], e, ALL);

    // Reset asserted while MEMWR waits, in the cycle memory would complete.
    do_reset(0);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    e = base_v(2'd1, 6'b011000); e.adrsrc = 1'b1;
    check_vec("memwr_wait", obs[0], e, ALL);
    step(0, 1'b1, 1'b0);
    check_vec("rst_in_wait", obs[0], 24'h0, strobe_mask());
    step(0, 1'b0, 1'b1);
    e = base_v(2'd1, 6'b011000); e.srca = 1'b1; e.srcb = 2'd2; e.ressrc = 2'd2;
    check_vec("fetch_stall_after_rst", obs[0], e, ALL);

    // Illegal is sticky across instructions and cleared by reset.
    do_reset(0);
    st_op = 2'd3; st_f = 6'd0; st_rd = 4'd0;
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    m = '0; m.ret = 1'b1; m.ill = 1'b1;
    e = '0; e.ret = 1'b1;
    check_vec("illegal_retire", obs[0], e, m);
    st_op = 2'd0; st_f = 6'b001000; st_rd = 4'd1;
    step(0, 1'b1, 1'b1);
    e = '0; e.ill = 1'b1;
    check_vec("illegal_set", obs[0], e, m);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    e.ret = 1'b1;
    check_vec("illegal_sticky", obs[0], e, m);
    do_reset(0);
    step(0, 1'b1, 1'b1);
    e = '0;
    check_vec("illegal_clear", obs[0], e, m);

    // Randomized instruction streams against the model, both instances.
    for (int sel = 0; sel < 2; sel++) begin
      do_reset(sel);
      for (int k = 0; k < 80; k++) begin
        rop   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        st_op = rop;
        st_f  = 6'($urandom);
        st_rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        build_trace(sel, st_op, st_f, st_rd, $urandom_range(0, 2), $urandom_range(0, 3));
        while (exp_q.size() > 0) begin
          logic [23:0] ev;
          logic        mv;
          ev = exp_q.pop_front();
          mv = mr_q.pop_front();
          step(sel, mv, 1'b1);
          check_vec(sel == 0 ? "rand_cycle_ext" : "rand_cycle_base", obs[sel], ev, ALL);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
